// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds FSM encoding, port ids, word width and the latched-request record.
package mem_arbiter_pkg;

  localparam int WORD_W = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              port;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between fetch and data ports, plus the
// next value of the fetch-starvation counter for the arbitration cycle.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2,
  parameter int CNT_W      = 2
) (
  input  logic             i_if_req,
  input  logic             i_d_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_grant_vld,
  output logic             o_grant_port,
  output logic [CNT_W-1:0] o_starve_nxt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic w_fetch_forced;

  assign w_fetch_forced = i_if_req && (i_starve_cnt == MAX_CNT);

  always_comb begin
    o_grant_vld  = i_if_req | i_d_req;
    o_grant_port = PORT_IF;
    o_starve_nxt = '0;
    if (i_d_req && !w_fetch_forced) begin
      o_grant_port = PORT_D;
      // Only a data grant that overtakes a waiting fetch counts as starvation.
      if (i_if_req) begin
        o_starve_nxt = i_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, one access in flight.
// Data wins by default; fetch is forced through after STARVE_MAX overtaking data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_done,
  output logic [WORD_W-1:0] d_rdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_write_signal,
  output logic              mem_read_signal,
  input  logic [WORD_W-1:0] mem_data_out
);

  localparam int         CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [2:0] LAT   = 3'(READ_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  req_t              r_req;
  req_t              w_win;
  logic [CNT_W-1:0]  r_starve;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic [2:0]        r_wait_cnt;
  logic [WORD_W-1:0] r_if_rdata;
  logic [WORD_W-1:0] r_d_rdata;
  logic              w_grant_vld;
  logic              w_grant_port;
  logic              w_wait_end;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .i_if_req    (if_req),
    .i_d_req     (d_req),
    .i_starve_cnt(r_starve),
    .o_grant_vld (w_grant_vld),
    .o_grant_port(w_grant_port),
    .o_starve_nxt(w_starve_nxt)
  );

  // r_wait_cnt numbers the WAIT cycles from 1; ACCESS is cycle 0 of the read window.
  assign w_wait_end = (r_wait_cnt == LAT);

  // A fetch keeps the previous write data so mem_data_in does not move for reads.
  always_comb begin
    w_win.port  = w_grant_port;
    w_win.we    = 1'b0;
    w_win.addr  = if_addr;
    w_win.wdata = r_req.wdata;
    if (w_grant_port == PORT_D) begin
      w_win.we    = d_we;
      w_win.addr  = d_addr;
      w_win.wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_vld) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = r_req.we ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (w_wait_end) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= '0;
      r_starve   <= '0;
      r_wait_cnt <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_starve <= w_starve_nxt;
        if (w_grant_vld) begin
          r_req <= w_win;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_wait_cnt <= 3'd1;
      end else if (r_state == ST_WAIT && !w_wait_end) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
      if (r_state == ST_WAIT && w_wait_end) begin
        if (r_req.port == PORT_D) begin
          r_d_rdata <= mem_data_out;
        end else begin
          r_if_rdata <= mem_data_out;
        end
      end
    end
  end

  // Read strobe spans READ_LAT cycles counted from ACCESS; the last WAIT cycle only captures.
  always_comb begin
    mem_write_signal = 1'b0;
    mem_read_signal  = 1'b0;
    if_done          = 1'b0;
    d_done           = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        mem_write_signal = r_req.we;
        mem_read_signal  = ~r_req.we;
      end
      ST_WAIT: mem_read_signal = (r_wait_cnt < LAT);
      ST_DONE: begin
        if_done = (r_req.port == PORT_IF);
        d_done  = (r_req.port == PORT_D);
      end
      default: ;
    endcase
  end

  assign mem_addr    = r_req.addr;
  assign mem_data_in = r_req.wdata;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance a uses READ_LAT=1, instance b READ_LAT=3.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int RL_A = 1;
  localparam int RL_B = 3;

  typedef struct {
    logic        port;
    logic        has_data;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic        if_req  [2];
  logic [31:0] if_addr [2];
  logic        if_done [2];
  logic [31:0] if_rdata[2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_din   [2];
  logic [31:0] m_dout  [2];
  logic        m_we    [2];
  logic        m_re    [2];

  logic [31:0] mem0[64];
  logic [31:0] mem1[64];
  logic [31:0] pa[RL_A];
  logic [31:0] pb[RL_B];
  int          wr_cnt[2];
  int          rd_cnt[2];
  logic [31:0] last_wa[2];
  logic [31:0] last_wd[2];

  // Hand-derived grant order with both requests held (READ_LAT=1, STARVE_MAX=2).
  logic arb_port[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int   arb_off [6] = '{2, 5, 9, 12, 15, 19};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.READ_LAT(RL_A), .STARVE_MAX(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_done(if_done[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_done(d_done[0]), .d_rdata(d_rdata[0]),
    .mem_addr(m_addr[0]), .mem_data_in(m_din[0]), .mem_write_signal(m_we[0]),
    .mem_read_signal(m_re[0]), .mem_data_out(m_dout[0])
  );

  mem_arbiter #(.READ_LAT(RL_B), .STARVE_MAX(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_done(if_done[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_done(d_done[1]), .d_rdata(d_rdata[1]),
    .mem_addr(m_addr[1]), .mem_data_in(m_din[1]), .mem_write_signal(m_we[1]),
    .mem_read_signal(m_re[1]), .mem_data_out(m_dout[1])
  );

  // Memory models: data appears READ_LAT cycles after the first read cycle, junk otherwise.
  always @(posedge clk) begin
    if (m_we[0]) mem0[m_addr[0][5:0]] <= m_din[0];
    for (int i = RL_A - 1; i > 0; i--) pa[i] <= pa[i-1];
    pa[0] <= m_re[0] ? mem0[m_addr[0][5:0]] : 32'hDEAD_BEEF;
  end
  assign m_dout[0] = pa[RL_A-1];

  always @(posedge clk) begin
    if (m_we[1]) mem1[m_addr[1][5:0]] <= m_din[1];
    for (int i = RL_B - 1; i > 0; i--) pb[i] <= pb[i-1];
    pb[0] <= m_re[1] ? mem1[m_addr[1][5:0]] : 32'hDEAD_BEEF;
  end
  assign m_dout[1] = pb[RL_B-1];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_we[k] === 1'b1) begin
        wr_cnt[k]++;
        last_wa[k] = m_addr[k];
        last_wd[k] = m_din[k];
      end
      if (m_re[k] === 1'b1) rd_cnt[k]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int k);
    exp_t        e;
    logic [31:0] rd;
    chk($sformatf("no_overlap%0d", k), 32'(if_done[k] & d_done[k]), 32'd0);
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done%0d: got done at cycle %0d, required none", k, cyc);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("done_port%0d", k), 32'(d_done[k]), 32'(e.port));
      chk($sformatf("done_cycle%0d", k), cyc, e.cyc);
      if (e.has_data) begin
        rd = e.port ? d_rdata[k] : if_rdata[k];
        chk($sformatf("rdata%0d", k), rd, e.rdata);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (if_done[k] || d_done[k]) mon(k);
      end
    end
  end

  task automatic push(input int k, input logic port, input logic has_data,
                      input logic [31:0] rdata, input int done_cyc);
    exp_t e;
    e.port     = port;
    e.has_data = has_data;
    e.rdata    = rdata;
    e.cyc      = done_cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Issue one request, hold it until its expected done cycle, then drop it.
  task automatic access(input int k, input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata);
    logic has_data;
    int   done_cyc;
    int   n;
    @(posedge clk);
    #1;
    has_data = (port == 1'b0) || !we;
    done_cyc = cyc + 2 + (has_data ? ((k == 0) ? RL_A : RL_B) : 0);
    push(k, port, has_data, rdata, done_cyc);
    if (port) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    n = done_cyc - cyc;
    repeat (n) @(posedge clk);
    #1;
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_if_done"},  32'(if_done[k]), 32'd0);
    chk({tag, "_d_done"},   32'(d_done[k]),  32'd0);
    chk({tag, "_if_rdata"}, if_rdata[k],     32'd0);
    chk({tag, "_d_rdata"},  d_rdata[k],      32'd0);
    chk({tag, "_mem_addr"}, m_addr[k],       32'd0);
    chk({tag, "_mem_din"},  m_din[k],        32'd0);
    chk({tag, "_mem_we"},   32'(m_we[k]),    32'd0);
    chk({tag, "_mem_re"},   32'(m_re[k]),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int r;
    int c;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k]  = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    access(0, 1'b1, 1'b1, 32'd4,  32'h8C22_0000, 32'd0);
    access(1, 1'b1, 1'b1, 32'd20, 32'hCAFE_0014, 32'd0);

    // Data write then read-back on the same address.
    w = wr_cnt[0];
    access(0, 1'b1, 1'b1, 32'd10, 32'd123, 32'd0);
    chk("wr_pulses", wr_cnt[0] - w, 32'd1);
    chk("wr_addr",   last_wa[0],    32'd10);
    chk("wr_data",   last_wd[0],    32'd123);
    access(0, 1'b1, 1'b0, 32'd10, 32'd0, 32'd123);

    // Fetch is a pure read.
    w = wr_cnt[0];
    r = rd_cnt[0];
    access(0, 1'b0, 1'b0, 32'd4, 32'd0, 32'h8C22_0000);
    chk("fetch_no_write",    wr_cnt[0] - w, 32'd0);
    chk("fetch_read_cycles", rd_cnt[0] - r, 32'(RL_A));
    chk("d_rdata_hold",      d_rdata[0],    32'd123);

    // Both ports held continuously: D, D, IF, D, D, IF.
    @(posedge clk);
    #1;
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      push(0, arb_port[i], !arb_port[i], 32'h8C22_0000, c + arb_off[i]);
    end
    if_req[0] = 1'b1; if_addr[0] = 32'd4;
    d_req[0]  = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd30; d_wdata[0] = 32'd77;
    repeat (19) @(posedge clk);
    #1;
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    chk("arb_last_write", last_wd[0], 32'd77);

    // Reset asserted during WAIT of a data read aborts it silently.
    @(posedge clk);
    #1;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd10;
    repeat (2) @(posedge clk);
    #3;
    rst_n    = 1'b0;
    d_req[0] = 1'b0;
    #1;
    chk_zero(0, "abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 32'd10, 32'd0, 32'd123);
    chk("if_rdata_after_rst", if_rdata[0], 32'd0);

    // READ_LAT=3 instance: read strobe 3 cycles, done 5 cycles after sampling.
    r = rd_cnt[1];
    access(1, 1'b1, 1'b0, 32'd20, 32'd0, 32'hCAFE_0014);
    chk("rl3_read_cycles", rd_cnt[1] - r, 32'(RL_B));

    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
